axis_fifo: RTL and testbench

//   Synchronous AXI-stream FIFO placed directly upstream of the delay line.

---
 rtl/axis_fifo_if.sv | 12 +
 rtl/axis_fifo.sv | 80 ++++++++
 tb/tb_axis_fifo.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axis_fifo_if.sv
// AXI-stream handshake bundle: payload, valid and ready.
// The master drives data/valid and the slave drives ready.
interface axis_if #(
   parameter int BITWIDTH = 1
);
   logic [BITWIDTH-1:0] data;
   logic                valid;
   logic                ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/axis_fifo.sv
// Synchronous first-word-fall-through AXI-stream FIFO.
// Storage is an array with asynchronous read, so the head word is visible
// one cycle after it is written. Pointers carry an extra wrap bit so that
// full and empty can be told apart without a separate flag.
module axis_fifo #(
   parameter int DEPTH        = 16,
   parameter int BITWIDTH     = 1,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     rst,
   axis_if.slave                    src,
   axis_if.master                   dest,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE      = 1;
   localparam logic [AW:0] AFULL_LV = AFULL_THRESH[AW:0];

   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic                active_q;
   logic [BITWIDTH-1:0] mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   // active_q keeps src.ready low while in reset and lets it rise on the
   // first edge after release, without depending on any input handshake.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign src.ready   = active_q && !full;
   assign dest.valid  = !empty;
   // Empty (including reset) presents zero rather than stale storage.
   assign dest.data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign count       = count_q;
   assign almost_full = (count_q >= AFULL_LV);

   assign push = src.valid && src.ready;
   assign pop  = dest.valid && dest.ready;

   // Next-state for pointers and occupancy from the two handshakes.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE;
      if (push && !pop)
         count_d = count_q + ONE;
      else if (pop && !push)
         count_d = count_q - ONE;
   end

   // Control state; reset discards all queued words immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         active_q <= 1'b1;
      end
   end

   // Storage write; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= src.data;
   end
endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: directed phases plus a random phase,
// all checked against a queue-based reference model.
module tb_axis_fifo;
   localparam int DEPTH = 16;
   localparam int BW    = 8;
   localparam int AF    = DEPTH - 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] count;
   logic       almost_full;

   axis_if #(.BITWIDTH(BW)) src_if ();
   axis_if #(.BITWIDTH(BW)) dest_if ();

   axis_fifo #(.DEPTH(DEPTH), .BITWIDTH(BW), .AFULL_THRESH(AF)) dut (
      .clk         (clk),
      .rst         (rst),
      .src         (src_if),
      .dest        (dest_if),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   logic [BW-1:0] q [$];
   int evals = 0;
   int fails = 0;
   int pushes = 0;
   int pops = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      evals++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the negedge, compare against the model,
   // then apply the handshakes the model says will happen at the posedge.
   task automatic step(input logic sv, input logic [BW-1:0] d, input logic dr);
      logic m_push, m_pop;
      logic [BW-1:0] popped;
      src_if.valid  = sv;
      src_if.data   = d;
      dest_if.ready = dr;
      #1;
      check("src_ready", {31'd0, src_if.ready}, {31'd0, q.size() < DEPTH});
      check("dest_valid", {31'd0, dest_if.valid}, {31'd0, q.size() != 0});
      check("count", {27'd0, count}, q.size());
      check("almost_full", {31'd0, almost_full}, {31'd0, q.size() >= AF});
      if (q.size() != 0) check("dest_data", {24'd0, dest_if.data}, {24'd0, q[0]});
      m_push = sv && (q.size() < DEPTH);
      m_pop  = dr && (q.size() != 0);
      @(posedge clk);
      if (m_pop) begin
         popped = q.pop_front();
         pops++;
      end
      if (m_push) begin
         q.push_back(d);
         pushes++;
      end
      @(negedge clk);
   endtask

   task automatic release_reset();
      src_if.valid  = 1'b0;
      dest_if.ready = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_release", {31'd0, src_if.ready}, 32'd1);
   endtask

   initial begin
      int n;
      src_if.valid  = 1'b0;
      src_if.data   = '0;
      dest_if.ready = 1'b0;

      // Reset then idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_src_ready", {31'd0, src_if.ready}, 32'd0);
         check("rst_dest_valid", {31'd0, dest_if.valid}, 32'd0);
         check("rst_count", {27'd0, count}, 32'd0);
         check("rst_afull", {31'd0, almost_full}, 32'd0);
         check("rst_dest_data", {24'd0, dest_if.data}, 32'd0);
      end
      release_reset();
      $display("phase reset/idle done: evals=%0d", evals);

      // Fill to full, then hold a 17th word that must not be accepted
      for (int i = 0; i < DEPTH; i++) step(1'b1, BW'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b0);
      check("full_count", {27'd0, count}, 32'd16);
      $display("phase fill done: count=%0d", count);

      // Drain in order
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
      check("drained_valid", {31'd0, dest_if.valid}, 32'd0);
      $display("phase drain done: pops=%0d", pops);

      // Streaming: push and pop every cycle
      for (int i = 0; i < 100; i++) step(1'b1, BW'(8'h40 + i), 1'b1);
      step(1'b0, 8'h00, 1'b1);
      $display("phase stream done: pushes=%0d pops=%0d", pushes, pops);

      // Random valid/ready over 1000 words, crossing many pointer wraps
      n = 0;
      pushes = 0;
      while (pushes < 1000 && n < 8000) begin
         step($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 1) == 1);
         n++;
      end
      check("random_budget", pushes >= 1000, 32'd1);
      n = 0;
      while (q.size() != 0 && n < 100) begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end
      check("random_drain_valid", {31'd0, dest_if.valid}, 32'd0);
      $display("phase random done: pushes=%0d cycles=%0d", pushes, n);

      // Reset mid-burst with nine words queued
      for (int i = 0; i < 9; i++) step(1'b1, BW'(8'hC0 + i), 1'b0);
      check("pre_reset_count", {27'd0, count}, 32'd9);
      #2 rst = 1'b1;
      #1;
      check("async_count", {27'd0, count}, 32'd0);
      check("async_dest_valid", {31'd0, dest_if.valid}, 32'd0);
      check("async_src_ready", {31'd0, src_if.ready}, 32'd0);
      check("async_afull", {31'd0, almost_full}, 32'd0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      release_reset();
      for (int i = 0; i < 4; i++) step(1'b1, BW'(8'h50 + i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
      check("post_reset_empty", {31'd0, dest_if.valid}, 32'd0);
      $display("phase reset-mid-burst done: evals=%0d", evals);

      $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
      $finish;
   end
endmodule
